// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle memory-access stage.
// Contents: opcode constants (Ins[31:26]), FSM state type and small opcode
// classification helpers used by ma_stage_mc.
package mips_pkg;

  localparam logic [5:0] OP_JAL = 6'd3;
  localparam logic [5:0] OP_LB  = 6'd32;
  localparam logic [5:0] OP_LH  = 6'd33;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_LBU = 6'd36;
  localparam logic [5:0] OP_LHU = 6'd37;
  localparam logic [5:0] OP_SB  = 6'd40;
  localparam logic [5:0] OP_SH  = 6'd41;
  localparam logic [5:0] OP_SW  = 6'd43;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  function automatic logic is_load(logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(logic [5:0] op, logic [1:0] a);
    if (op inside {OP_LH, OP_LHU, OP_SH}) return a[0];
    if (op inside {OP_LW, OP_SW}) return a != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/ma_stage_mc_if.sv
// Execute-to-write-back bus of the memory-access stage.
// Upstream (master) drives: valid, result (ALU result / byte address),
//   rdata2 (store data), next_pc (PC+4), ins (instruction).
// Stage (slave) drives: wdata (write-back data), stall, done, ad_err.
interface ma_stage_mc_if;
  logic        valid;
  logic [31:0] result;
  logic [31:0] rdata2;
  logic [31:0] next_pc;
  logic [31:0] ins;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        ad_err;

  modport master (
    output valid, result, rdata2, next_pc, ins,
    input  wdata, stall, done, ad_err
  );

  modport slave (
    input  valid, result, rdata2, next_pc, ins,
    output wdata, stall, done, ad_err
  );
endinterface

// File: rtl/dm_bytemem.sv
// DEPTH x 32-bit data memory with per-byte write enables.
// Ports: clk (write clock), be (byte-lane enables, lane 0 = bits 7:0),
//   addr (word index), wdata (write data, already lane-aligned),
//   rdata (combinational read of the addressed word).
// Contents are not reset.
module dm_bytemem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ma_stage_mc.sv
// Multi-cycle MIPS memory-access stage.
// Ports: clk, rst (async, active high), bus (slave side of ma_stage_mc_if).
// Non-memory instructions complete combinationally in the presenting cycle.
// Loads/stores are latched on acceptance, wait WAIT_CYCLES cycles, commit
// on the last wait edge, then report done for one cycle.
module ma_stage_mc
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  ma_stage_mc_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  // cnt only ever holds WAIT_CYCLES-1 down to 0.
  localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        op_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [31:0]       load_q;

  logic [5:0]        live_op;
  logic              live_mem;
  logic              accept;
  logic              commit;
  logic [5:0]        eff_op;
  logic [ADDR_W+1:0] eff_addr;
  logic [31:0]       eff_sdata;
  logic              eff_mis;
  logic              done_err;

  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;

  logic              unused_ins;

  assign live_op  = bus.ins[31:26];
  assign live_mem = is_load(live_op) | is_store(live_op);
  assign accept   = (state_q == IDLE) && bus.valid && live_mem;

  // With zero wait states the access commits on the acceptance edge, so the
  // memory path must see the live inputs while in IDLE.
  assign eff_op    = (state_q == IDLE) ? live_op : op_q;
  assign eff_addr  = (state_q == IDLE) ? bus.result[ADDR_W+1:0] : addr_q;
  assign eff_sdata = (state_q == IDLE) ? bus.rdata2 : sdata_q;
  assign eff_mis   = misaligned(eff_op, eff_addr[1:0]);

  // rst gating keeps a reset coinciding with the commit edge from writing.
  assign commit = ~rst & (((state_q == WAIT) && (cnt_q == '0)) ||
                          ((WAIT_CYCLES == 0) && accept));

  assign done_err = misaligned(op_q, addr_q[1:0]);

  // Store lane alignment: replicate the data and select lanes with be.
  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = eff_sdata;
    if (commit && is_store(eff_op) && !eff_mis) begin
      unique case (eff_op)
        OP_SB: begin
          mem_be    = 4'b0001 << eff_addr[1:0];
          mem_wdata = {4{eff_sdata[7:0]}};
        end
        OP_SH: begin
          mem_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{eff_sdata[15:0]}};
        end
        default: mem_be = 4'b1111;
      endcase
    end
  end

  dm_bytemem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .be    (mem_be),
    .addr  (eff_addr[ADDR_W+1:2]),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Load lane extraction and extension.
  assign lane_byte = 8'(mem_rdata >> {eff_addr[1:0], 3'b000});
  assign lane_half = eff_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    unique case (eff_op)
      OP_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_ext = {24'h0, lane_byte};
      OP_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_ext = {16'h0, lane_half};
      default: load_ext = mem_rdata;
    endcase
    if (eff_mis) load_ext = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= live_op;
        addr_q  <= bus.result[ADDR_W+1:0];
        sdata_q <= bus.rdata2;
      end
      if (commit && is_load(eff_op)) load_q <= load_ext;
    end
  end

  always_comb begin
    bus.stall  = 1'b0;
    bus.done   = 1'b0;
    bus.ad_err = 1'b0;
    bus.wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          if (live_mem) begin
            bus.stall = 1'b1;
          end else begin
            bus.done  = 1'b1;
            bus.wdata = (live_op == OP_JAL) ? bus.next_pc : bus.result;
          end
        end
      end
      WAIT: bus.stall = 1'b1;
      DONE: begin
        bus.done   = 1'b1;
        bus.ad_err = done_err;
        bus.wdata  = (is_load(op_q) && !done_err) ? load_q : '0;
      end
      default: ;
    endcase
  end

  assign unused_ins = ^bus.ins[25:0];

endmodule

// File: tb/tb_ma_stage_mc.sv
// Self-checking bench for ma_stage_mc: one instance with two wait states,
// one with zero wait states, sharing clock and reset.
module tb_ma_stage_mc;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic [31:0] w;
    logic        e;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] res;
    logic [31:0] rd2;
    logic [31:0] npc;
    bit          mutate;
    logic [31:0] ew;
    logic        ee;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  ma_stage_mc_if bus2 ();
  ma_stage_mc_if bus0 ();

  ma_stage_mc #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  ma_stage_mc #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  function automatic op_t mk(string n, logic [5:0] opc, logic [31:0] res, logic [31:0] rd2,
                             logic [31:0] npc, bit mut, logic [31:0] ew, logic ee);
    op_t o;
    o.name = n; o.ins = {opc, 26'h0155}; o.res = res; o.rd2 = rd2; o.npc = npc;
    o.mutate = mut; o.ew = ew; o.ee = ee;
    return o;
  endfunction

  function automatic int exp_lat(bit w0, logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    if (op inside {32, 33, 35, 36, 37, 40, 41, 43}) return w0 ? 1 : 3;
    return 0;
  endfunction

  task automatic idle_bus();
    bus2.valid = 1'b0; bus2.ins = '0; bus2.result = '0; bus2.rdata2 = '0; bus2.next_pc = '0;
    bus0.valid = 1'b0; bus0.ins = '0; bus0.result = '0; bus0.rdata2 = '0; bus0.next_pc = '0;
  endtask

  // Presents one instruction, waits (bounded) for done, returns what was seen.
  // mutate scribbles over ins/result/rdata2 after the acceptance edge.
  task automatic drive_op(input bit w0, input op_t o, output logic [31:0] gw,
                          output logic ge, output int lat, output int stalls);
    logic d, s;
    lat = -1; stalls = 0; gw = 'x; ge = 'x;
    if (w0) begin
      bus0.valid = 1'b1; bus0.ins = o.ins; bus0.result = o.res;
      bus0.rdata2 = o.rd2; bus0.next_pc = o.npc;
    end else begin
      bus2.valid = 1'b1; bus2.ins = o.ins; bus2.result = o.res;
      bus2.rdata2 = o.rd2; bus2.next_pc = o.npc;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      d = w0 ? bus0.done : bus2.done;
      s = w0 ? bus0.stall : bus2.stall;
      if (d) begin
        gw  = w0 ? bus0.wdata : bus2.wdata;
        ge  = w0 ? bus0.ad_err : bus2.ad_err;
        lat = c;
        break;
      end
      if (s) stalls++;
      @(posedge clk); #1;
      if (o.mutate) begin
        if (w0) begin
          bus0.ins = {6'd36, 26'h0}; bus0.result = 32'h0000_0FFC; bus0.rdata2 = 32'h0BAD_0BAD;
        end else begin
          bus2.ins = {6'd36, 26'h0}; bus2.result = 32'h0000_0FFC; bus2.rdata2 = 32'h0BAD_0BAD;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus2.stall, bus2.done, bus2.ad_err, bus2.wdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_w2 outputs got %h required 0",
               {bus2.stall, bus2.done, bus2.ad_err, bus2.wdata});
    end
    n_tests++;
    if ({bus0.stall, bus0.done, bus0.ad_err, bus0.wdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_w0 outputs got %h required 0",
               {bus0.stall, bus0.done, bus0.ad_err, bus0.wdata});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    op_t ops[$];
    logic [31:0] gw; logic ge; int gl, gs; exp_t e;
    ops.push_back(mk("sw_20", 6'd43, 32'h20, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0));
    ops.push_back(mk("lw_20", 6'd35, 32'h20, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0));
    foreach (ops[i]) begin
      sb.push_back('{w: ops[i].ew, e: ops[i].ee, lat: exp_lat(1'b0, ops[i].ins)});
      drive_op(1'b0, ops[i], gw, ge, gl, gs);
      e = sb.pop_front();
      n_tests++;
      if (gw !== e.w || ge !== e.e) begin
        n_fail++;
        $display("FAIL %s wdata/aderr got %h/%b required %h/%b", ops[i].name, gw, ge, e.w, e.e);
      end
      n_tests++;
      if (gl != e.lat || gs != e.lat) begin
        n_fail++;
        $display("FAIL %s latency/stalls got %0d/%0d required %0d", ops[i].name, gl, gs, e.lat);
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_subword();
    op_t ops[$];
    logic [31:0] gw; logic ge; int gl, gs; exp_t e;
    ops.push_back(mk("sb_21", 6'd40, 32'h21, 32'h000000A5, 0, 1'b1, 32'h0, 1'b0));
    ops.push_back(mk("lw_20b", 6'd35, 32'h20, 0, 0, 1'b0, 32'hDEADA5EF, 1'b0));
    ops.push_back(mk("lb_21", 6'd32, 32'h21, 0, 0, 1'b0, 32'hFFFFFFA5, 1'b0));
    ops.push_back(mk("lbu_21", 6'd36, 32'h21, 0, 0, 1'b0, 32'h000000A5, 1'b0));
    ops.push_back(mk("lhu_22", 6'd37, 32'h22, 0, 0, 1'b0, 32'h0000DEAD, 1'b0));
    ops.push_back(mk("lh_22", 6'd33, 32'h22, 0, 0, 1'b0, 32'hFFFFDEAD, 1'b0));
    ops.push_back(mk("lbu_20", 6'd36, 32'h20, 0, 0, 1'b0, 32'h000000EF, 1'b0));
    foreach (ops[i]) begin
      sb.push_back('{w: ops[i].ew, e: ops[i].ee, lat: exp_lat(1'b0, ops[i].ins)});
      drive_op(1'b0, ops[i], gw, ge, gl, gs);
      e = sb.pop_front();
      n_tests++;
      if (gw !== e.w || ge !== e.e) begin
        n_fail++;
        $display("FAIL %s wdata/aderr got %h/%b required %h/%b", ops[i].name, gw, ge, e.w, e.e);
      end
      n_tests++;
      if (gl != e.lat || gs != e.lat) begin
        n_fail++;
        $display("FAIL %s latency/stalls got %0d/%0d required %0d", ops[i].name, gl, gs, e.lat);
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    op_t ops[$];
    logic [31:0] gw; logic ge; int gl, gs; exp_t e;
    ops.push_back(mk("rtype", 6'd0, 32'h12345678, 32'h5, 32'h00400004, 1'b0, 32'h12345678, 1'b0));
    ops.push_back(mk("jal", 6'd3, 32'h00000AB0, 32'h5, 32'h00400008, 1'b0, 32'h00400008, 1'b0));
    ops.push_back(mk("addi", 6'd8, 32'hFFFF0001, 32'h0, 32'h00400010, 1'b0, 32'hFFFF0001, 1'b0));
    foreach (ops[i]) begin
      sb.push_back('{w: ops[i].ew, e: ops[i].ee, lat: exp_lat(1'b0, ops[i].ins)});
      drive_op(1'b0, ops[i], gw, ge, gl, gs);
      e = sb.pop_front();
      n_tests++;
      if (gw !== e.w || ge !== e.e) begin
        n_fail++;
        $display("FAIL %s wdata/aderr got %h/%b required %h/%b", ops[i].name, gw, ge, e.w, e.e);
      end
      n_tests++;
      if (gl != e.lat || gs != e.lat) begin
        n_fail++;
        $display("FAIL %s latency/stalls got %0d/%0d required %0d", ops[i].name, gl, gs, e.lat);
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    op_t ops[$];
    logic [31:0] gw; logic ge; int gl, gs; exp_t e;
    ops.push_back(mk("sh_23", 6'd41, 32'h23, 32'h00001234, 0, 1'b0, 32'h0, 1'b1));
    ops.push_back(mk("lw_20c", 6'd35, 32'h20, 0, 0, 1'b0, 32'hDEADA5EF, 1'b0));
    ops.push_back(mk("lw_22", 6'd35, 32'h22, 0, 0, 1'b0, 32'h0, 1'b1));
    ops.push_back(mk("sw_21", 6'd43, 32'h21, 32'h0, 0, 1'b0, 32'h0, 1'b1));
    ops.push_back(mk("lhu_21", 6'd37, 32'h21, 0, 0, 1'b0, 32'h0, 1'b1));
    ops.push_back(mk("lw_20d", 6'd35, 32'h20, 0, 0, 1'b0, 32'hDEADA5EF, 1'b0));
    foreach (ops[i]) begin
      sb.push_back('{w: ops[i].ew, e: ops[i].ee, lat: exp_lat(1'b0, ops[i].ins)});
      drive_op(1'b0, ops[i], gw, ge, gl, gs);
      e = sb.pop_front();
      n_tests++;
      if (gw !== e.w || ge !== e.e) begin
        n_fail++;
        $display("FAIL %s wdata/aderr got %h/%b required %h/%b", ops[i].name, gw, ge, e.w, e.e);
      end
      n_tests++;
      if (gl != e.lat || gs != e.lat) begin
        n_fail++;
        $display("FAIL %s latency/stalls got %0d/%0d required %0d", ops[i].name, gl, gs, e.lat);
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    op_t ops[$];
    logic [31:0] gw; logic ge; int gl, gs; exp_t e;
    ops.push_back(mk("sw_11", 6'd43, 32'h20, 32'h11111111, 0, 1'b0, 32'h0, 1'b0));
    sb.push_back('{w: ops[0].ew, e: ops[0].ee, lat: 3});
    drive_op(1'b0, ops[0], gw, ge, gl, gs);
    e = sb.pop_front();
    n_tests++;
    if (gw !== e.w || ge !== e.e || gl != e.lat) begin
      n_fail++;
      $display("FAIL sw_11 wdata/aderr/lat got %h/%b/%0d required %h/%b/%0d",
               gw, ge, gl, e.w, e.e, e.lat);
    end
    // Accept SW 0x55555555, then reset during the first wait cycle.
    bus2.ins = {6'd43, 26'h0}; bus2.result = 32'h20; bus2.rdata2 = 32'h55555555; bus2.valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_bus();
    #1;
    n_tests++;
    if ({bus2.stall, bus2.done, bus2.ad_err, bus2.wdata} !== 35'h0) begin
      n_fail++;
      $display("FAIL abort_outputs got %h required 0",
               {bus2.stall, bus2.done, bus2.ad_err, bus2.wdata});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ops.delete();
    ops.push_back(mk("lw_after_abort", 6'd35, 32'h20, 0, 0, 1'b0, 32'h11111111, 1'b0));
    ops.push_back(mk("sw_alias", 6'd43, 32'h20 + 4 * DEPTH, 32'hCAFEF00D, 0, 1'b0, 32'h0, 1'b0));
    ops.push_back(mk("lw_alias", 6'd35, 32'h20, 0, 0, 1'b0, 32'hCAFEF00D, 1'b0));
    ops.push_back(mk("lw_alias_hi", 6'd35, 32'h20 + 8 * DEPTH, 0, 0, 1'b0, 32'hCAFEF00D, 1'b0));
    foreach (ops[i]) begin
      sb.push_back('{w: ops[i].ew, e: ops[i].ee, lat: exp_lat(1'b0, ops[i].ins)});
      drive_op(1'b0, ops[i], gw, ge, gl, gs);
      e = sb.pop_front();
      n_tests++;
      if (gw !== e.w || ge !== e.e || gl != e.lat || gs != e.lat) begin
        n_fail++;
        $display("FAIL %s wdata/aderr/lat/stalls got %h/%b/%0d/%0d required %h/%b/%0d",
                 ops[i].name, gw, ge, gl, gs, e.w, e.e, e.lat);
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    logic [31:0] gw; logic ge; int gl, gs; exp_t e;
    ops.push_back(mk("w0_sw_40", 6'd43, 32'h40, 32'h89ABCDEF, 0, 1'b1, 32'h0, 1'b0));
    ops.push_back(mk("w0_lw_40", 6'd35, 32'h40, 0, 0, 1'b1, 32'h89ABCDEF, 1'b0));
    ops.push_back(mk("w0_sh_42", 6'd41, 32'h42, 32'hFFFF8001, 0, 1'b1, 32'h0, 1'b0));
    ops.push_back(mk("w0_lw_40b", 6'd35, 32'h40, 0, 0, 1'b0, 32'h8001CDEF, 1'b0));
    ops.push_back(mk("w0_lh_42", 6'd33, 32'h42, 0, 0, 1'b0, 32'hFFFF8001, 1'b0));
    ops.push_back(mk("w0_lw_41", 6'd35, 32'h41, 0, 0, 1'b0, 32'h0, 1'b1));
    foreach (ops[i]) begin
      sb.push_back('{w: ops[i].ew, e: ops[i].ee, lat: exp_lat(1'b1, ops[i].ins)});
      drive_op(1'b1, ops[i], gw, ge, gl, gs);
      e = sb.pop_front();
      n_tests++;
      if (gw !== e.w || ge !== e.e) begin
        n_fail++;
        $display("FAIL %s wdata/aderr got %h/%b required %h/%b", ops[i].name, gw, ge, e.w, e.e);
      end
      n_tests++;
      if (gl != e.lat || gs != e.lat) begin
        n_fail++;
        $display("FAIL %s latency/stalls got %0d/%0d required %0d", ops[i].name, gl, gs, e.lat);
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_nonmem();
    test_misalign();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
